// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with status flags, a passed-through tag and an
// optional iterative shift-add multiplier. One result slot on the output side.
module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int TAG_W  = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_ill,
  output logic             busy
);

  localparam int MSB   = WIDTH - 1;
  localparam int CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               done_reg, done_next;
  logic [TAG_W-1:0]   mtag_reg, mtag_next;

  logic               out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [TAG_W-1:0]   out_tag_reg, out_tag_next;
  logic               z_reg, z_next;
  logic               c_reg, c_next;
  logic               v_reg, v_next;
  logic               ill_reg, ill_next;

  logic               slot_free;
  logic               accept;
  logic               is_mul;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_ill;

  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] prod_sum;
  logic [2*WIDTH-1:0] mul_final;
  logic               mul_last;

  logic               load_out;
  logic [WIDTH-1:0]   ld_res;
  logic [TAG_W-1:0]   ld_tag;
  logic               ld_c, ld_v, ld_ill;

  assign slot_free = !out_valid_reg || out_ready;
  assign in_ready  = (state_reg == ST_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_mul    = (MUL_EN != 0) && (opcode == OP_MUL);

  // Carry-out of the subtract adder is the inverted borrow.
  assign add_sum = {1'b0, inputA} + {1'b0, inputB};
  assign sub_sum = {1'b0, inputA} + {1'b0, ~inputB} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (inputA[MSB] == inputB[MSB]) && (add_sum[MSB] != inputA[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = ~sub_sum[WIDTH];
        alu_v   = (inputA[MSB] != inputB[MSB]) && (sub_sum[MSB] != inputA[MSB]);
      end
      OP_AND:  alu_res = inputA & inputB;
      OP_OR:   alu_res = inputA | inputB;
      OP_XOR:  alu_res = inputA ^ inputB;
      OP_NOT:  alu_res = ~inputA;
      // MUL only reaches this path when the multiplier is disabled.
      default: alu_ill = 1'b1;
    endcase
  end

  // Partial product for the current multiplier bit.
  generate
    for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_partial
      assign partial[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign prod_sum  = acc_reg + partial;
  assign mul_final = done_reg ? acc_reg : prod_sum;
  assign mul_last  = done_reg || (cnt_reg == CNT_LAST);

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    done_next   = done_reg;
    mtag_next   = mtag_reg;
    load_out    = 1'b0;
    ld_res      = alu_res;
    ld_tag      = in_tag;
    ld_c        = alu_c;
    ld_v        = alu_v;
    ld_ill      = alu_ill;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_next  = ST_MUL;
            acc_next    = '0;
            mcand_next  = {{WIDTH{1'b0}}, inputA};
            mplier_next = inputB;
            cnt_next    = '0;
            done_next   = 1'b0;
            mtag_next   = in_tag;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          // Product complete: publish when the slot is free, else park it in the accumulator.
          if (slot_free) begin
            load_out   = 1'b1;
            ld_res     = mul_final[WIDTH-1:0];
            ld_tag     = mtag_reg;
            ld_c       = |mul_final[2*WIDTH-1:WIDTH];
            ld_v       = 1'b0;
            ld_ill     = 1'b0;
            state_next = ST_IDLE;
            done_next  = 1'b0;
          end else begin
            acc_next  = mul_final;
            done_next = 1'b1;
          end
        end else begin
          acc_next    = prod_sum;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          cnt_next    = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    result_next  = result_reg;
    out_tag_next = out_tag_reg;
    z_next       = z_reg;
    c_next       = c_reg;
    v_next       = v_reg;
    ill_next     = ill_reg;
    if (load_out) begin
      out_valid_next = 1'b1;
      result_next    = ld_res;
      out_tag_next   = ld_tag;
      z_next         = (ld_res == '0);
      c_next         = ld_c;
      v_next         = ld_v;
      ill_next       = ld_ill;
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end else begin
      out_valid_next = out_valid_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      mtag_reg      <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      out_tag_reg   <= '0;
      z_reg         <= 1'b0;
      c_reg         <= 1'b0;
      v_reg         <= 1'b0;
      ill_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      cnt_reg       <= cnt_next;
      done_reg      <= done_next;
      mtag_reg      <= mtag_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      out_tag_reg   <= out_tag_next;
      z_reg         <= z_next;
      c_reg         <= c_next;
      v_reg         <= v_next;
      ill_reg       <= ill_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign out_tag   = out_tag_reg;
  assign flag_z    = z_reg;
  assign flag_c    = c_reg;
  assign flag_v    = v_reg;
  assign flag_ill  = ill_reg;
  assign busy      = (state_reg == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results are queued at acceptance
// and compared when the output handshake completes.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid1;
  logic        in_ready, in_ready1;
  logic [2:0]  opcode;
  logic [15:0] inputA, inputB;
  logic [3:0]  in_tag;
  logic        out_valid, out_valid1;
  logic        out_ready, out_ready1;
  logic [15:0] result, result1;
  logic [3:0]  out_tag, out_tag1;
  logic        flag_z, flag_c, flag_v, flag_ill, busy;
  logic        flag_z1, flag_c1, flag_v1, flag_ill1, busy1;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .TAG_W(4), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .inputA(inputA), .inputB(inputB), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_ill(flag_ill), .busy(busy)
  );

  alu_pipe #(.WIDTH(16), .TAG_W(4), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .opcode(opcode), .inputA(inputA), .inputB(inputB), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1), .out_tag(out_tag1),
    .flag_z(flag_z1), .flag_c(flag_c1), .flag_v(flag_v1), .flag_ill(flag_ill1), .busy(busy1)
  );

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Packed as {result, tag, z, c, v, ill}.
  function automatic logic [23:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [3:0] t);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r;
    logic        c, v, ill;
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; c = (p[31:16] != 16'h0); end
      default: ill = 1'b1;
    endcase
    return {r, t, (r == 16'h0), c, v, ill};
  endfunction

  // Output monitor: samples mid-low-phase, after the driver has settled its inputs.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        logic [23:0] exp;
        exp = sb.pop_front();
        check_val("result", {result, out_tag, flag_z, flag_c, flag_v, flag_ill}, exp);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] t, input logic rdy, output int waited);
    int budget;
    @(negedge clk);
    opcode = op; inputA = a; inputB = b; in_tag = t;
    out_ready = rdy; in_valid = 1'b1;
    #1;
    waited = 0;
    budget = 200;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      waited++;
      budget--;
    end
    if (!in_ready) begin
      check_val("send_timeout", 1, 0);
      in_valid = 1'b0;
    end else begin
      sb.push_back(model(op, a, b, t));
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget;
    @(negedge clk);
    out_ready = 1'b1;
    budget = 100;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_val("drain", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic stale;
    rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b1; out_ready1 = 1'b1;
    opcode = '0; inputA = '0; inputB = '0; in_tag = '0;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_state", {out_valid, busy, flag_z, flag_c, flag_v, flag_ill, in_ready}, 7'b0000001);
    check_val("rst_result", {result, out_tag}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry wrap to zero, latency 1.
    send(3'd0, 16'hFFFF, 16'h0001, 4'd3, 1'b1, w);
    @(negedge clk); #1;
    check_val("add_latency", out_valid, 1);
    check_val("add_flags", {flag_z, flag_c, flag_v, out_tag}, {3'b110, 4'd3});

    // Back-to-back single-cycle ops.
    send(3'd0, 16'h7FFF, 16'h0001, 4'd1, 1'b1, w);
    send(3'd1, 16'h0003, 16'h0005, 4'd2, 1'b1, w);
    check_val("b2b_wait", w, 0);
    send(3'd1, 16'h8000, 16'h0001, 4'd4, 1'b1, w);
    check_val("b2b_wait2", w, 0);
    send(3'd5, 16'h00FF, 16'h1234, 4'd5, 1'b1, w);
    wait_drain();

    // Multiply timing: busy with in_ready low for WIDTH cycles.
    send(3'd6, 16'h0012, 16'h0034, 4'd6, 1'b1, w);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      check_val("mul_busy", {busy, in_ready, out_valid}, 3'b100);
    end
    @(negedge clk); #1;
    check_val("mul_done", {busy, out_valid}, 2'b01);
    wait_drain();
    send(3'd6, 16'h0100, 16'h0100, 4'd7, 1'b1, w);
    send(3'd6, 16'hFFFF, 16'hFFFF, 4'd8, 1'b1, w);
    wait_drain();

    // Backpressure: result held, then pop and accept on the same edge.
    send(3'd2, 16'hF0F0, 16'h0FF0, 4'd9, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_val("bp_hold", {out_valid, in_ready, result, out_tag}, {2'b10, 16'h00F0, 4'd9});
    end
    send(3'd0, 16'h0001, 16'h0002, 4'd10, 1'b1, w);
    check_val("bp_same_edge", w, 0);
    wait_drain();

    // Illegal opcode.
    send(3'd7, 16'h1234, 16'h5678, 4'd11, 1'b1, w);
    @(negedge clk); #1;
    check_val("ill_latency", {out_valid, flag_ill, flag_z, result}, {3'b111, 16'h0});
    wait_drain();

    // Opcode 110 with the multiplier disabled.
    @(negedge clk);
    opcode = 3'd6; inputA = 16'h0003; inputB = 16'h0004; in_tag = 4'd12; in_valid1 = 1'b1;
    #1;
    check_val("nomul_ready", in_ready1, 1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk); #1;
    check_val("nomul_ill", {out_valid1, flag_ill1, flag_z1, flag_c1, flag_v1, busy1, result1, out_tag1},
              {6'b111000, 16'h0, 4'd12});

    // Random mix with random backpressure.
    for (int i = 0; i < 24; i++) begin
      send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'(i),
           ($urandom_range(0, 3) != 0), w);
    end
    wait_drain();

    // Reset in the middle of a multiply.
    send(3'd6, 16'h0055, 16'h0066, 4'd13, 1'b1, w);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mul_reset", {out_valid, busy}, 2'b00);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check_val("no_stale", stale, 0);
    send(3'd0, 16'h0010, 16'h0020, 4'd14, 1'b1, w);
    @(negedge clk); #1;
    check_val("post_reset_add", {out_valid, result, out_tag}, {1'b1, 16'h0030, 4'd14});
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
